// File: rtl/phys_reg_file_rp_if.sv
// Bus bundle for the physical register file: read ports, write ports and
// the rename/dispatch allocate request.
interface phys_reg_file_rp_if #(
   parameter int unsigned DEPTH = 32,
   parameter int unsigned WIDTH = 64,
   parameter int unsigned NRD   = 2,
   parameter int unsigned NWR   = 1
);
   localparam int unsigned AW = $clog2(DEPTH);

   logic [NRD-1:0][AW-1:0]    rd_addr;
   logic [NRD-1:0][WIDTH-1:0] rd_data;
   logic [NRD-1:0]            rd_ready;
   logic [NWR-1:0]            wr_en;
   logic [NWR-1:0][AW-1:0]    wr_addr;
   logic [NWR-1:0][WIDTH-1:0] wr_data;
   logic                      alloc_en;
   logic [AW-1:0]             alloc_addr;

   modport master (
      output rd_addr, wr_en, wr_addr, wr_data, alloc_en, alloc_addr,
      input  rd_data, rd_ready
   );

   modport slave (
      input  rd_addr, wr_en, wr_addr, wr_data, alloc_en, alloc_addr,
      output rd_data, rd_ready
   );
endinterface

// File: rtl/phys_reg_file_rp.sv
// Physical register file with registered read ports, write-to-read bypass,
// a hardwired zero register and a per-register ready scoreboard.
module phys_reg_file_rp #(
   parameter int unsigned DEPTH    = 32,
   parameter int unsigned WIDTH    = 64,
   parameter int unsigned NRD      = 2,
   parameter int unsigned NWR      = 1,
   parameter int unsigned ZERO_REG = 31
) (
   input logic                clk,
   input logic                reset,
   phys_reg_file_rp_if.slave  bus
);
   localparam int unsigned    AW = $clog2(DEPTH);
   localparam logic [AW-1:0]  ZR = AW'(ZERO_REG);

   logic [WIDTH-1:0]          r_mem [DEPTH];
   logic [DEPTH-1:0]          r_ready;
   logic [NRD-1:0][WIDTH-1:0] r_rd_data;
   logic [NRD-1:0]            r_rd_ready;

   logic [NWR-1:0]            w_wr_ok;
   logic [NRD-1:0]            w_byp_hit;
   logic [NRD-1:0][WIDTH-1:0] w_byp_data;
   logic [NRD-1:0][WIDTH-1:0] w_rd_data_nxt;
   logic [NRD-1:0]            w_rd_ready_nxt;

   // Writes to the zero register are dropped everywhere, including bypass
   always_comb begin
      w_wr_ok = '0;
      for (int unsigned w = 0; w < NWR; w++) begin
         w_wr_ok[w] = bus.wr_en[w] && (bus.wr_addr[w] != ZR);
      end
   end

   // Ascending scan so the highest-index matching write port wins
   always_comb begin
      w_byp_hit  = '0;
      w_byp_data = '0;
      for (int unsigned r = 0; r < NRD; r++) begin
         for (int unsigned w = 0; w < NWR; w++) begin
            if (w_wr_ok[w] && (bus.wr_addr[w] == bus.rd_addr[r])) begin
               w_byp_hit[r]  = 1'b1;
               w_byp_data[r] = bus.wr_data[w];
            end
         end
      end
   end

   always_comb begin
      w_rd_data_nxt  = '0;
      w_rd_ready_nxt = '0;
      for (int unsigned r = 0; r < NRD; r++) begin
         if (bus.rd_addr[r] == ZR) begin
            w_rd_data_nxt[r]  = '0;
            w_rd_ready_nxt[r] = 1'b1;
         end else if (w_byp_hit[r]) begin
            w_rd_data_nxt[r]  = w_byp_data[r];
            w_rd_ready_nxt[r] = 1'b1;
         end else begin
            w_rd_data_nxt[r]  = r_mem[bus.rd_addr[r]];
            w_rd_ready_nxt[r] = r_ready[bus.rd_addr[r]];
         end
      end
   end

   // Alloc clear is ordered after the write set so a new mapping supersedes it
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
         r_ready    <= '1;
         r_rd_data  <= '0;
         r_rd_ready <= '0;
      end else begin
         for (int unsigned w = 0; w < NWR; w++) begin
            if (w_wr_ok[w]) begin
               r_mem[bus.wr_addr[w]]   <= bus.wr_data[w];
               r_ready[bus.wr_addr[w]] <= 1'b1;
            end
         end
         if (bus.alloc_en && (bus.alloc_addr != ZR)) begin
            r_ready[bus.alloc_addr] <= 1'b0;
         end
         r_rd_data  <= w_rd_data_nxt;
         r_rd_ready <= w_rd_ready_nxt;
      end
   end

   assign bus.rd_data  = r_rd_data;
   assign bus.rd_ready = r_rd_ready;
endmodule

// File: tb/tb_phys_reg_file_rp.sv
// Scoreboard bench for phys_reg_file_rp: directed scenarios then random traffic.
module tb_phys_reg_file_rp;
   localparam int unsigned DEPTH = 32;
   localparam int unsigned WIDTH = 64;
   localparam int unsigned NRD   = 2;
   localparam int unsigned NWR   = 2;
   localparam int unsigned ZREG  = 31;
   localparam int unsigned AW    = $clog2(DEPTH);

   typedef struct {
      logic [NRD-1:0][WIDTH-1:0] d;
      logic [NRD-1:0]            r;
   } exp_t;

   logic clk;
   logic reset;
   int   n_vec;
   int   n_err;
   exp_t sb_q[$];

   logic [WIDTH-1:0] m_mem [DEPTH];
   logic             m_rdy [DEPTH];

   phys_reg_file_rp_if #(.DEPTH(DEPTH), .WIDTH(WIDTH), .NRD(NRD), .NWR(NWR)) bus ();

   phys_reg_file_rp #(
      .DEPTH(DEPTH), .WIDTH(WIDTH), .NRD(NRD), .NWR(NWR), .ZERO_REG(ZREG)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic idle();
      reset          = 1'b0;
      bus.rd_addr    = '0;
      bus.wr_en      = '0;
      bus.wr_addr    = '0;
      bus.wr_data    = '0;
      bus.alloc_en   = 1'b0;
      bus.alloc_addr = '0;
   endtask

   // Predict from the reference state, clock once, update state, then score
   task automatic step();
      exp_t e;
      exp_t o;
      for (int r = 0; r < NRD; r++) begin
         if (reset) begin
            e.d[r] = '0;
            e.r[r] = 1'b0;
         end else if (int'(bus.rd_addr[r]) == ZREG) begin
            e.d[r] = '0;
            e.r[r] = 1'b1;
         end else begin
            e.d[r] = m_mem[bus.rd_addr[r]];
            e.r[r] = m_rdy[bus.rd_addr[r]];
            for (int w = 0; w < NWR; w++) begin
               if (bus.wr_en[w] && int'(bus.wr_addr[w]) != ZREG && bus.wr_addr[w] == bus.rd_addr[r]) begin
                  e.d[r] = bus.wr_data[w];
                  e.r[r] = 1'b1;
               end
            end
         end
      end
      sb_q.push_back(e);
      @(posedge clk);
      if (reset) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            m_mem[i] = '0;
            m_rdy[i] = 1'b1;
         end
      end else begin
         for (int w = 0; w < NWR; w++) begin
            if (bus.wr_en[w] && int'(bus.wr_addr[w]) != ZREG) begin
               m_mem[bus.wr_addr[w]] = bus.wr_data[w];
               m_rdy[bus.wr_addr[w]] = 1'b1;
            end
         end
         if (bus.alloc_en && int'(bus.alloc_addr) != ZREG) m_rdy[bus.alloc_addr] = 1'b0;
      end
      #1;
      o = sb_q.pop_front();
      for (int r = 0; r < NRD; r++) begin
         chk($sformatf("sb_data[%0d]", r), bus.rd_data[r], o.d[r]);
         chk($sformatf("sb_rdy[%0d]", r), WIDTH'(bus.rd_ready[r]), WIDTH'(o.r[r]));
      end
   endtask

   function automatic logic [AW-1:0] rand_addr();
      if ($urandom_range(0, 1) == 1) return AW'($urandom_range(28, 31));
      return AW'($urandom_range(0, 31));
   endfunction

   initial begin
      n_vec = 0;
      n_err = 0;
      for (int i = 0; i < int'(DEPTH); i++) begin
         m_mem[i] = 'x;
         m_rdy[i] = 1'bx;
      end

      // Reset cycle: outputs held at zero / not-ready
      idle();
      reset = 1'b1;
      bus.rd_addr[0] = AW'(0);
      bus.rd_addr[1] = AW'(5);
      bus.wr_en = 2'b01;
      bus.wr_addr[0] = AW'(5);
      bus.wr_data[0] = 64'h1234;
      step();
      chk("rst_data", bus.rd_data[1], 64'h0);
      chk("rst_rdy", WIDTH'(bus.rd_ready[0]), 64'h0);

      idle();
      bus.rd_addr[0] = AW'(0);
      bus.rd_addr[1] = AW'(5);
      step();
      chk("post_rst_data", bus.rd_data[1], 64'h0);
      chk("post_rst_rdy", WIDTH'(bus.rd_ready[1]), 64'h1);

      // Write then read next cycle
      idle();
      bus.wr_en = 2'b01;
      bus.wr_addr[0] = AW'(3);
      bus.wr_data[0] = 64'hDEADBEEF_00000001;
      step();
      idle();
      bus.rd_addr[0] = AW'(3);
      step();
      chk("wr_rd_data", bus.rd_data[0], 64'hDEADBEEF_00000001);

      // Same-cycle bypass
      idle();
      bus.wr_en = 2'b01;
      bus.wr_addr[0] = AW'(7);
      bus.wr_data[0] = 64'h55;
      bus.rd_addr[0] = AW'(7);
      step();
      chk("byp_data", bus.rd_data[0], 64'h55);
      chk("byp_rdy", WIDTH'(bus.rd_ready[0]), 64'h1);

      // Zero register ignores writes and never bypasses
      idle();
      bus.wr_en = 2'b10;
      bus.wr_addr[1] = AW'(31);
      bus.wr_data[1] = 64'hFFFF;
      bus.rd_addr[1] = AW'(31);
      bus.alloc_en = 1'b1;
      bus.alloc_addr = AW'(31);
      step();
      chk("zr_same_data", bus.rd_data[1], 64'h0);
      chk("zr_same_rdy", WIDTH'(bus.rd_ready[1]), 64'h1);
      idle();
      bus.rd_addr[0] = AW'(31);
      step();
      chk("zr_next_data", bus.rd_data[0], 64'h0);
      chk("zr_next_rdy", WIDTH'(bus.rd_ready[0]), 64'h1);

      // Alloc: same-cycle read sees old ready, later read sees 0
      idle();
      bus.alloc_en = 1'b1;
      bus.alloc_addr = AW'(9);
      bus.rd_addr[0] = AW'(9);
      step();
      chk("alloc_same_rdy", WIDTH'(bus.rd_ready[0]), 64'h1);
      idle();
      bus.rd_addr[0] = AW'(9);
      step();
      chk("alloc_rdy", WIDTH'(bus.rd_ready[0]), 64'h0);
      idle();
      bus.wr_en = 2'b01;
      bus.wr_addr[0] = AW'(9);
      bus.wr_data[0] = 64'h12;
      step();
      idle();
      bus.rd_addr[0] = AW'(9);
      step();
      chk("wb_data", bus.rd_data[0], 64'h12);
      chk("wb_rdy", WIDTH'(bus.rd_ready[0]), 64'h1);

      // Alloc + write same register: data written, ready ends low, bypass shows ready
      idle();
      bus.alloc_en = 1'b1;
      bus.alloc_addr = AW'(9);
      bus.wr_en = 2'b01;
      bus.wr_addr[0] = AW'(9);
      bus.wr_data[0] = 64'h34;
      bus.rd_addr[1] = AW'(9);
      step();
      chk("aw_byp_data", bus.rd_data[1], 64'h34);
      chk("aw_byp_rdy", WIDTH'(bus.rd_ready[1]), 64'h1);
      idle();
      bus.rd_addr[0] = AW'(9);
      step();
      chk("aw_data", bus.rd_data[0], 64'h34);
      chk("aw_rdy", WIDTH'(bus.rd_ready[0]), 64'h0);

      // Write-port conflict: highest index wins
      idle();
      bus.wr_en = 2'b11;
      bus.wr_addr[0] = AW'(4);
      bus.wr_addr[1] = AW'(4);
      bus.wr_data[0] = 64'hA;
      bus.wr_data[1] = 64'hB;
      bus.rd_addr[0] = AW'(4);
      step();
      chk("conf_byp", bus.rd_data[0], 64'hB);
      idle();
      bus.rd_addr[0] = AW'(4);
      bus.rd_addr[1] = AW'(4);
      step();
      chk("conf_p0", bus.rd_data[0], 64'hB);
      chk("conf_p1", bus.rd_data[1], 64'hB);

      // Mid-stream reset, then first read returns 0 / ready
      idle();
      reset = 1'b1;
      bus.alloc_en = 1'b1;
      bus.alloc_addr = AW'(3);
      step();
      idle();
      bus.rd_addr[0] = AW'(3);
      bus.rd_addr[1] = AW'(9);
      step();
      chk("mid_rst_data", bus.rd_data[0], 64'h0);
      chk("mid_rst_rdy", WIDTH'(bus.rd_ready[1]), 64'h1);

      // Random traffic against the reference model
      for (int c = 0; c < 500; c++) begin
         idle();
         reset = ($urandom_range(0, 63) == 0);
         for (int r = 0; r < NRD; r++) bus.rd_addr[r] = rand_addr();
         for (int w = 0; w < NWR; w++) begin
            bus.wr_en[w]   = ($urandom_range(0, 2) != 0);
            bus.wr_addr[w] = rand_addr();
            bus.wr_data[w] = {$urandom, $urandom};
         end
         bus.alloc_en   = ($urandom_range(0, 1) == 1);
         bus.alloc_addr = rand_addr();
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/phys_reg_file_rp.md
Name: phys_reg_file_rp

Overview:
- Parametrised physical register file for the out-of-order core; generalises the combinational 32:1 x 64-bit read mux into a registered multi-port structure.
- NRD registered read ports, NWR synchronous write ports, same-cycle write-to-read bypass, a hardwired zero register, and a per-register ready scoreboard.
- Rename/dispatch allocates destination registers; the scoreboard clears them and CDB writeback sets them.
- Issue logic reads operand data plus ready status through the read ports.

Parameters:
- DEPTH, 32, number of physical registers (power of 2, >= 2)
- WIDTH, 64, data width in bits
- NRD, 2, number of read ports
- NWR, 1, number of write ports
- ZERO_REG, 31, index that always reads 0, ignores writes and is always ready
- AW, $clog2(DEPTH), address width (derived; not overridden)

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- rd_addr  in  [NRD-1:0][AW-1:0]  read address per port
- rd_data  out  [NRD-1:0][WIDTH-1:0]  registered read data
- rd_ready  out  [NRD-1:0]  registered ready bit of the addressed register
- wr_en  in  [NWR-1:0]  write enable per port
- wr_addr  in  [NWR-1:0][AW-1:0]  write address per port
- wr_data  in  [NWR-1:0][WIDTH-1:0]  write data per port
- alloc_en  in  1  allocate (mark not-ready) one register
- alloc_addr  in  [AW-1:0]  register being allocated

Behaviour:
- Reset (clk edge with reset=1):
  - All DEPTH data entries are set to 0.
  - All ready bits are set to 1.
  - rd_data = 0 and rd_ready = 0 on every port.
  - Reset overrides wr_en and alloc_en in the same cycle.
- Write: on the clk edge with wr_en[w]=1 and wr_addr[w]!=ZERO_REG:
  - The entry is loaded with wr_data[w].
  - Its ready bit is set to 1.
- Write-port conflict: if several enabled ports target the same address, the highest-index port wins for both data and bypass.
- Read latency is 1 cycle. At each edge, rd_data[r] captures the addressed entry's current value and rd_ready[r] captures its current ready bit.
- Bypass: if any enabled write port targets rd_addr[r] in the same cycle, rd_data[r] captures the winning wr_data and rd_ready[r] captures 1. This is write-before-read semantics.
- Zero register:
  - A read of ZERO_REG always yields rd_data=0 and rd_ready=1.
  - A write to ZERO_REG is ignored and is not bypassed.
  - An alloc of ZERO_REG is ignored.
- Alloc: alloc_en=1 clears the ready bit of alloc_addr at the edge. Data is unchanged.
- Alloc and write to the same register in the same cycle:
  - The data is written.
  - The ready bit ends at 0 (alloc wins), because the new mapping supersedes the old producer.
  - A same-cycle read bypass on that address returns the write data and rd_ready=1, since it reflects the completing producer.
- Alloc and read of the same address in the same cycle: with no write, the read sees the pre-alloc ready bit. The ready bit drops in the following cycle.
- Read ports are independent. Any number of ports may read the same address.
- Out-of-range addresses cannot occur, because DEPTH is a power of 2.
- Reset asserted mid-stream clears everything at that edge. The first read issued in the cycle after reset returns 0 with ready 1.

Test Plan:
- Reset, then read addresses 0 and 5 on ports 0 and 1 -> both ports return rd_data=0 and rd_ready=1 one cycle later; rd_data=0 and rd_ready=0 during the reset cycle.
- Write 0xDEADBEEF_00000001 to reg 3 at cycle t, then read reg 3 at t+1 -> rd_data=0xDEADBEEF_00000001 at t+2.
- Write reg 7 = 0x55 and read reg 7 in the same cycle -> rd_data=0x55 and rd_ready=1 on the next cycle (bypass).
- Write 0xFFFF to reg 31 (ZERO_REG), read reg 31 same and next cycle -> rd_data=0 and rd_ready=1 on both.
- Alloc reg 9, then read reg 9 -> rd_ready=0. Write reg 9 = 0x12, then read -> rd_ready=1 and rd_data=0x12. Alloc and write reg 9 in the same cycle with a later read -> rd_data=written value, rd_ready=0.
- NWR=2, both ports write reg 4 (0xA on port 0, 0xB on port 1) while port 0 reads reg 4 -> bypass gives 0xB; a later read gives 0xB.
